// File: rtl/hi_lo_muldiv_if.sv
// Request/result bundle between the control path and the HI/LO mul/div unit.
interface hi_lo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             HI_write_enable;
  logic             LO_write_enable;
  logic [WIDTH-1:0] HI_write_data;
  logic [WIDTH-1:0] LO_write_data;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
  );
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine writing HI/LO; one iteration per cycle.
module hi_lo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  hi_lo_muldiv_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_iter;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] operand_m;
  logic [WIDTH-1:0] a_raw;
  logic [AW-1:0]    acc;

  logic             busy;
  logic             done;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;

  logic             is_signed_in;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    acc_next;
  logic [AW-1:0]    prod_neg;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.HI_write_enable = hi_we;
  assign bus.LO_write_enable = lo_we;
  assign bus.HI_write_data   = hi_data;
  assign bus.LO_write_data   = lo_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          last_iter  = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes and signs at accept; op[0]=0 selects the signed variants.
  always_comb begin
    is_signed_in = ~bus.op[0];
    a_neg_in     = is_signed_in & bus.operand_a[WIDTH-1];
    b_neg_in     = is_signed_in & bus.operand_b[WIDTH-1];
    a_mag        = a_neg_in ? (~bus.operand_a) + WIDTH'(1) : bus.operand_a;
    b_mag        = b_neg_in ? (~bus.operand_b) + WIDTH'(1) : bus.operand_b;
  end

  // One shift-add or restoring-divide step, plus sign-corrected results of that step.
  always_comb begin
    mul_add  = acc[0] ? operand_m : '0;
    mul_sum  = {1'b0, acc[AW-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    rem_sh   = acc[AW-1:WIDTH-1];
    div_ge   = rem_sh >= {1'b0, operand_m};
    rem_sub  = rem_sh[WIDTH-1:0] - operand_m;
    div_next = {(div_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    acc_next = is_div ? div_next : mul_next;
    prod_neg = (~acc_next) + AW'(1);
    quot     = acc_next[WIDTH-1:0];
    rem      = acc_next[AW-1:WIDTH];

    hi_res = '0;
    lo_res = '0;
    if (!is_div) begin
      {hi_res, lo_res} = neg_q ? prod_neg : acc_next;
    end else if (div_zero) begin
      // Divide by zero: raw dividend in HI, all ones in LO, no sign fix-up.
      hi_res = a_raw;
      lo_res = '1;
    end else begin
      lo_res = neg_q ? (~quot) + WIDTH'(1) : quot;
      hi_res = neg_r ? (~rem) + WIDTH'(1) : rem;
    end
  end

  // Datapath and registered outputs; results land on the edge entering FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      operand_m <= '0;
      a_raw     <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi_we     <= 1'b0;
      lo_we     <= 1'b0;
      hi_data   <= '0;
      lo_data   <= '0;
    end else begin
      done  <= 1'b0;
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      if (accept) begin
        is_div    <= bus.op[1];
        neg_q     <= a_neg_in ^ b_neg_in;
        neg_r     <= a_neg_in;
        div_zero  <= (bus.operand_b == '0);
        a_raw     <= bus.operand_a;
        operand_m <= bus.op[1] ? b_mag : a_mag;
        acc       <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        count     <= '0;
        busy      <= 1'b1;
      end else if (state == RUN) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (last_iter) begin
          hi_data <= hi_res;
          lo_data <= lo_res;
          done    <= 1'b1;
          hi_we   <= 1'b1;
          lo_we   <= 1'b1;
        end
      end else if (state == FINISH) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Scoreboard bench for hi_lo_muldiv_unit: expected HI/LO and strobe cycle queued at issue.
module tb_hi_lo_muldiv_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   edge_cnt;
  int   free_at;
  int   n_cmp;
  int   n_err;
  exp_t scb[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  hi_lo_muldiv_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sbv;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = '0;
    case (op)
      MULT:  res = 64'(sa * sbv);
      MULTU: res = {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Drive one start cycle from a negedge; queue an expectation only if the unit is free.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int e);
    logic [63:0] r;
    e = edge_cnt;
    if (e >= free_at) begin
      r = model(op, a, b);
      scb.push_back('{r[63:32], r[31:0], e + 33});
      free_at = e + 34;
    end
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op        = 2'($urandom);
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (scb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(scb.size()), 64'(0));
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard, at the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done || bus.HI_write_enable || bus.LO_write_enable) begin
      check("strobe_set", 64'({bus.done, bus.HI_write_enable, bus.LO_write_enable}), 64'(3'b111));
      check("strobe_pending", 64'(scb.size() > 0), 64'(1));
      if (scb.size() > 0) begin
        e = scb.pop_front();
        check("hi", 64'(bus.HI_write_data), 64'(e.hi));
        check("lo", 64'(bus.LO_write_data), 64'(e.lo));
        check("strobe_cycle", 64'(edge_cnt), 64'(e.cyc));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  d_op [7];
  logic [31:0] d_a  [7];
  logic [31:0] d_b  [7];

  initial begin
    int e0;
    int e1;
    int e2;
    n_cmp = 0; n_err = 0; free_at = 0; edge_cnt = 0;
    last_hi = '0; last_lo = '0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;

    d_op[0] = MULT;  d_a[0] = 32'hFFFF_FFFD; d_b[0] = 32'h0000_0007;
    d_op[1] = DIV;   d_a[1] = 32'hFFFF_FFF9; d_b[1] = 32'h0000_0002;
    d_op[2] = DIV;   d_a[2] = 32'h8000_0000; d_b[2] = 32'hFFFF_FFFF;
    d_op[3] = DIVU;  d_a[3] = 32'h0000_0064; d_b[3] = 32'h0000_0000;
    d_op[4] = DIV;   d_a[4] = 32'hFFFF_FFFB; d_b[4] = 32'h0000_0000;
    d_op[5] = MULT;  d_a[5] = 32'h8000_0000; d_b[5] = 32'h8000_0000;
    d_op[6] = DIVU;  d_a[6] = 32'hFFFF_FFFF; d_b[6] = 32'h0000_0003;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_we",   64'({bus.HI_write_enable, bus.LO_write_enable}), 64'(0));
    check("rst_hi",   64'(bus.HI_write_data), 64'(0));
    check("rst_lo",   64'(bus.LO_write_data), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // MULTU max*max with cycle-exact busy checks.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
    check("busy_c1", 64'(bus.busy), 64'(1));
    while (edge_cnt < e0 + 33) @(negedge clk);
    check("busy_c33", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("busy_c34", 64'(bus.busy), 64'(0));
    check("hold_hi_c34", 64'(bus.HI_write_data), 64'(32'hFFFF_FFFE));
    check("hold_lo_c34", 64'(bus.LO_write_data), 64'(32'h0000_0001));
    drain(4);

    // Directed sign, overflow and divide-by-zero cases.
    for (int i = 0; i < 7; i++) begin
      issue(d_op[i], d_a[i], d_b[i], e0);
      drain(40);
      repeat (2) @(negedge clk);
      check("hold_hi", 64'(bus.HI_write_data), 64'(last_hi));
      check("hold_lo", 64'(bus.LO_write_data), 64'(last_lo));
    end

    // Start while busy is ignored; retry accepted on the first idle cycle.
    issue(MULTU, 32'd2, 32'd3, e0);
    repeat (4) @(negedge clk);
    issue(DIVU, 32'd9, 32'd2, e1);
    check("ignored_busy", 64'(bus.busy), 64'(1));
    while (edge_cnt < free_at) @(negedge clk);
    issue(DIVU, 32'd9, 32'd2, e2);
    check("retry_cycle", 64'(e2 - e0), 64'(34));
    drain(40);

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 2 == 1) rb = ~rb;
      issue(2'($urandom_range(0, 3)), ra, rb, e0);
      drain(40);
    end

    // Reset in cycle 10 of a MULTU aborts it with no strobe.
    issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, e0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_we",   64'({bus.HI_write_enable, bus.LO_write_enable}), 64'(0));
    check("mid_rst_hi",   64'(bus.HI_write_data), 64'(0));
    check("mid_rst_lo",   64'(bus.LO_write_data), 64'(0));
    scb.delete();
    free_at = 0;
    @(negedge clk);
    reset = 1'b0;
    while (edge_cnt < e0 + 41) @(negedge clk);
    issue(MULTU, 32'd5, 32'd5, e1);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
